data_chunk_top: RTL and testbench

- Double-buffered storage for one sparse data chunk: a MEM_SIZE-bit sparsemap plus up to MEM_SIZE packed non-zero bytes, with two banks.
- One bank is filled from the write bus while the other is read by the input-selector pipeline.
- Read side returns one PREFIX_SUM_SIZE-bit sparsemap word to the external priority encoder.
- It then converts the encoder's match position into the matching packed non-zero byte using a running prefix sum of set sparsemap bits.
- Two instances (IFM and filter) sit inside the input selector, both stepped by the same encoder outputs.

---
 rtl/data_chunk_top.sv | 103 ++++++++++
 tb/tb_data_chunk_top.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_chunk_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_chunk_top: double-buffered sparsemap + packed non-zero byte store   |
// | with prefix-sum lookup of the byte at the priority-encoder match.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module data_chunk_top #(
  parameter int MEM_SIZE        = 128,
  parameter int BUS_SIZE        = 8,
  parameter int PREFIX_SUM_SIZE = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [BUS_SIZE-1:0]                   wr_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0]                 wr_nonzero_data_i,
  input  logic                                  wr_valid_i,
  input  logic [$clog2(MEM_SIZE/BUS_SIZE)-1:0]  wr_count_i,
  input  logic                                  wr_sel_i,
  input  logic                                  rd_sel_i,
  output logic [7:0]                            rd_data_o,
  input  logic [$clog2(PREFIX_SUM_SIZE)-1:0]    pri_enc_match_addr_i,
  input  logic                                  pri_enc_end_i,
  input  logic                                  chunk_end_i,
  input  logic [$clog2(MEM_SIZE/PREFIX_SUM_SIZE)-1:0] rd_sparsemap_addr_i,
  output logic [PREFIX_SUM_SIZE-1:0]            rd_sparsemap_o
);

  localparam int c_ADDR_W = $clog2(MEM_SIZE);
  localparam int c_BUS_W  = $clog2(BUS_SIZE);
  localparam int c_PS_W   = $clog2(PREFIX_SUM_SIZE);
  localparam int c_CNT_W  = c_PS_W + 1;
  localparam int c_BASE_W = c_ADDR_W + 1;
  localparam logic [PREFIX_SUM_SIZE-1:0] c_ONE = PREFIX_SUM_SIZE'(1);

  function automatic logic [c_CNT_W-1:0] f_popcount(input logic [PREFIX_SUM_SIZE-1:0] v);
    logic [c_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < PREFIX_SUM_SIZE; i++) begin
      n = n + c_CNT_W'(v[i]);
    end
    return n;
  endfunction

  logic [MEM_SIZE-1:0]        r_sparsemap [2];
  logic [7:0]                 r_data      [2][MEM_SIZE];
  logic [c_BASE_W-1:0]        r_base;

  logic [c_ADDR_W-1:0]        w_wr_base;
  logic [c_ADDR_W-1:0]        w_rd_bit_base;
  logic [PREFIX_SUM_SIZE-1:0] w_low_mask;
  logic [c_CNT_W-1:0]         w_low_cnt;
  logic [c_CNT_W-1:0]         w_word_cnt;
  logic [c_ADDR_W-1:0]        w_rd_idx;
  logic [c_BASE_W-1:0]        w_base_next;

  // Beat/word indices are powers of two, so the bit offsets are plain concatenations.
  assign w_wr_base     = {wr_count_i, {c_BUS_W{1'b0}}};
  assign w_rd_bit_base = {rd_sparsemap_addr_i, {c_PS_W{1'b0}}};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < 2; b++) begin
        r_sparsemap[b] <= '0;
        for (int k = 0; k < MEM_SIZE; k++) begin
          r_data[b][k] <= '0;
        end
      end
    end else if (wr_valid_i) begin
      r_sparsemap[wr_sel_i][w_wr_base +: BUS_SIZE] <= wr_sparsemap_i;
      for (int i = 0; i < BUS_SIZE; i++) begin
        r_data[wr_sel_i][w_wr_base + c_ADDR_W'(i)] <= wr_nonzero_data_i[i*8 +: 8];
      end
    end
  end

  assign rd_sparsemap_o = r_sparsemap[rd_sel_i][w_rd_bit_base +: PREFIX_SUM_SIZE];

  // Bits strictly below the match position give its offset into the packed bytes.
  assign w_low_mask = (c_ONE << pri_enc_match_addr_i) - c_ONE;
  assign w_low_cnt  = f_popcount(rd_sparsemap_o & w_low_mask);
  assign w_word_cnt = f_popcount(rd_sparsemap_o);
  assign w_rd_idx   = r_base[c_ADDR_W-1:0] + c_ADDR_W'(w_low_cnt);
  assign rd_data_o  = r_data[rd_sel_i][w_rd_idx];

  always_comb begin
    w_base_next = r_base;
    if (chunk_end_i) begin
      w_base_next = '0;
    end else if (pri_enc_end_i) begin
      w_base_next = r_base + c_BASE_W'(w_word_cnt);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_base <= '0;
    end else begin
      r_base <= w_base_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_chunk_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_chunk_top: directed and randomized self-checking bench for       |
// | data_chunk_top against a bit/byte array reference model.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_data_chunk_top;

  localparam int MEM_SIZE = 128;
  localparam int BUS_SIZE = 8;
  localparam int PS_SIZE  = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  wr_sparsemap_i;
  logic [63:0] wr_nonzero_data_i;
  logic        wr_valid_i;
  logic [3:0]  wr_count_i;
  logic        wr_sel_i;
  logic        rd_sel_i;
  logic [7:0]  rd_data_o;
  logic [2:0]  pri_enc_match_addr_i;
  logic        pri_enc_end_i;
  logic        chunk_end_i;
  logic [3:0]  rd_sparsemap_addr_i;
  logic [7:0]  rd_sparsemap_o;

  int checks = 0;
  int errors = 0;

  data_chunk_top #(.MEM_SIZE(MEM_SIZE), .BUS_SIZE(BUS_SIZE), .PREFIX_SUM_SIZE(PS_SIZE)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_sparsemap_i(wr_sparsemap_i), .wr_nonzero_data_i(wr_nonzero_data_i),
    .wr_valid_i(wr_valid_i), .wr_count_i(wr_count_i), .wr_sel_i(wr_sel_i),
    .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o),
    .pri_enc_match_addr_i(pri_enc_match_addr_i), .pri_enc_end_i(pri_enc_end_i),
    .chunk_end_i(chunk_end_i), .rd_sparsemap_addr_i(rd_sparsemap_addr_i),
    .rd_sparsemap_o(rd_sparsemap_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: chunk as bit and byte arrays, base as a plain integer.
  bit   m_sm   [2][MEM_SIZE];
  logic [7:0] m_data [2][MEM_SIZE];
  int   m_base;

  function automatic logic [7:0] exp_word();
    logic [7:0] w;
    for (int j = 0; j < PS_SIZE; j++) w[j] = m_sm[rd_sel_i][int'(rd_sparsemap_addr_i)*PS_SIZE + j];
    return w;
  endfunction

  function automatic logic [7:0] exp_data();
    int low = 0;
    for (int j = 0; j < int'(pri_enc_match_addr_i); j++)
      low += int'(m_sm[rd_sel_i][int'(rd_sparsemap_addr_i)*PS_SIZE + j]);
    return m_data[rd_sel_i][(m_base + low) % MEM_SIZE];
  endfunction

  // Advance one clock: sample the inputs, take the edge, apply it to the model, park on negedge.
  task automatic tick();
    bit r, v, ws, pe, ce;
    int cnt, pop;
    logic [7:0]  sm;
    logic [63:0] d;
    logic [7:0]  w;
    r = rst_i; v = wr_valid_i; ws = wr_sel_i; pe = pri_enc_end_i; ce = chunk_end_i;
    cnt = int'(wr_count_i); sm = wr_sparsemap_i; d = wr_nonzero_data_i;
    w = exp_word();
    pop = 0;
    for (int j = 0; j < PS_SIZE; j++) pop += int'(w[j]);
    @(posedge clk_i);
    if (r) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < MEM_SIZE; k++) begin
          m_sm[b][k] = 1'b0;
          m_data[b][k] = 8'h00;
        end
      m_base = 0;
    end else begin
      if (v)
        for (int i = 0; i < BUS_SIZE; i++) begin
          m_sm[ws][cnt*BUS_SIZE + i] = sm[i];
          m_data[ws][cnt*BUS_SIZE + i] = d[i*8 +: 8];
        end
      if (ce) m_base = 0;
      else if (pe) m_base = (m_base + pop) % 256;
    end
    @(negedge clk_i);
  endtask

  task automatic wr(input bit bank, input int cnt, input logic [7:0] sm, input logic [63:0] d);
    wr_valid_i = 1'b1; wr_sel_i = bank; wr_count_i = 4'(cnt);
    wr_sparsemap_i = sm; wr_nonzero_data_i = d;
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++) begin
        rd_sel_i = 1'(s); rd_sparsemap_addr_i = 4'(a);
        pri_enc_match_addr_i = 3'($urandom_range(0, 7));
        #1;
        checks++;
        if (rd_sparsemap_o !== 8'h00) begin
          errors++;
          $display("FAIL reset_sparsemap sel=%0d addr=%0d: got %h want 00", s, a, rd_sparsemap_o);
        end
        checks++;
        if (rd_data_o !== 8'h00) begin
          errors++;
          $display("FAIL reset_data sel=%0d addr=%0d: got %h want 00", s, a, rd_data_o);
        end
        tick();
      end
  endtask

  task automatic test_read_basic();
    logic [63:0] d;
    int          m   [4] = '{0, 2, 5, 7};
    logic [7:0]  e   [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(8'h11 * (i + 1));
    wr(1'b0, 0, 8'hA5, d);
    rd_sel_i = 1'b0; rd_sparsemap_addr_i = 4'd0;
    for (int k = 0; k < 4; k++) begin
      pri_enc_match_addr_i = 3'(m[k]);
      #1;
      checks++;
      if (rd_sparsemap_o !== 8'hA5) begin
        errors++;
        $display("FAIL basic_sparsemap: got %h want a5", rd_sparsemap_o);
      end
      checks++;
      if (rd_data_o !== e[k]) begin
        errors++;
        $display("FAIL basic_match%0d: got %h want %h", m[k], rd_data_o, e[k]);
      end
      tick();
    end
  endtask

  task automatic test_base_accum();
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(8'h99 + i);
    wr(1'b0, 1, 8'hFF, d);
    rd_sparsemap_addr_i = 4'd0; pri_enc_end_i = 1'b1;
    tick();
    pri_enc_end_i = 1'b0;
    rd_sparsemap_addr_i = 4'd1; pri_enc_match_addr_i = 3'd0;
    #1;
    checks++;
    if (rd_sparsemap_o !== 8'hFF) begin
      errors++;
      $display("FAIL accum_sparsemap: got %h want ff", rd_sparsemap_o);
    end
    checks++;
    if (rd_data_o !== 8'h55) begin
      errors++;
      $display("FAIL accum_match0: got %h want 55", rd_data_o);
    end
    tick();
    pri_enc_match_addr_i = 3'd3;
    #1;
    checks++;
    if (rd_data_o !== 8'h88) begin
      errors++;
      $display("FAIL accum_match3: got %h want 88", rd_data_o);
    end
    tick();
  endtask

  task automatic test_chunk_end();
    rd_sparsemap_addr_i = 4'd0; pri_enc_end_i = 1'b1; chunk_end_i = 1'b1;
    tick();
    pri_enc_end_i = 1'b0; chunk_end_i = 1'b0; pri_enc_match_addr_i = 3'd0;
    #1;
    checks++;
    if (rd_data_o !== 8'h11) begin
      errors++;
      $display("FAIL chunk_end_priority: got %h want 11", rd_data_o);
    end
    tick();
  endtask

  task automatic test_double_buffer();
    rd_sel_i = 1'b0; rd_sparsemap_addr_i = 4'd0; pri_enc_match_addr_i = 3'd7;
    wr(1'b1, 0, 8'h01, 64'h0000_0000_0000_00EE);
    #1;
    checks++;
    if (rd_sparsemap_o !== 8'hA5 || rd_data_o !== 8'h44) begin
      errors++;
      $display("FAIL dbuf_bank0_kept: got %h/%h want a5/44", rd_sparsemap_o, rd_data_o);
    end
    rd_sel_i = 1'b1; pri_enc_match_addr_i = 3'd0;
    #1;
    checks++;
    if (rd_sparsemap_o !== 8'h01) begin
      errors++;
      $display("FAIL dbuf_bank1_sparsemap: got %h want 01", rd_sparsemap_o);
    end
    checks++;
    if (rd_data_o !== 8'hEE) begin
      errors++;
      $display("FAIL dbuf_bank1_data: got %h want ee", rd_data_o);
    end
    tick();
  endtask

  task automatic test_boundary();
    wr(1'b0, 15, 8'h80, {$urandom, $urandom});
    rd_sel_i = 1'b0; rd_sparsemap_addr_i = 4'd15; pri_enc_match_addr_i = 3'd7;
    #1;
    checks++;
    if (rd_sparsemap_o !== 8'h80) begin
      errors++;
      $display("FAIL last_beat_sparsemap: got %h want 80", rd_sparsemap_o);
    end
    tick();
    // Same-bank write into the word being read: old this cycle, new next cycle.
    wr_valid_i = 1'b1; wr_sel_i = 1'b0; wr_count_i = 4'd15;
    wr_sparsemap_i = 8'h3C; wr_nonzero_data_i = {$urandom, $urandom};
    #1;
    checks++;
    if (rd_sparsemap_o !== 8'h80) begin
      errors++;
      $display("FAIL same_bank_old: got %h want 80", rd_sparsemap_o);
    end
    tick();
    wr_valid_i = 1'b0;
    #1;
    checks++;
    if (rd_sparsemap_o !== 8'h3C) begin
      errors++;
      $display("FAIL same_bank_new: got %h want 3c", rd_sparsemap_o);
    end
    checks++;
    if (rd_data_o !== exp_data()) begin
      errors++;
      $display("FAIL same_bank_data: got %h want %h", rd_data_o, exp_data());
    end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wr_valid_i = 1'($urandom_range(0, 1));
      wr_sel_i = 1'($urandom); wr_count_i = 4'($urandom);
      wr_sparsemap_i = 8'($urandom); wr_nonzero_data_i = {$urandom, $urandom};
      rd_sel_i = 1'($urandom); rd_sparsemap_addr_i = 4'($urandom);
      pri_enc_match_addr_i = 3'($urandom);
      pri_enc_end_i = ($urandom_range(0, 3) == 0);
      chunk_end_i = ($urandom_range(0, 15) == 0);
      #1;
      checks++;
      if (rd_sparsemap_o !== exp_word()) begin
        errors++;
        $display("FAIL rand_sparsemap n=%0d: got %h want %h", n, rd_sparsemap_o, exp_word());
      end
      checks++;
      if (rd_data_o !== exp_data()) begin
        errors++;
        $display("FAIL rand_data n=%0d: got %h want %h", n, rd_data_o, exp_data());
      end
      tick();
    end
    wr_valid_i = 1'b0; pri_enc_end_i = 1'b0; chunk_end_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr_valid_i = 1'b1; wr_sel_i = 1'b1; wr_count_i = 4'd3;
    wr_sparsemap_i = 8'hFF; wr_nonzero_data_i = {$urandom, $urandom};
    pri_enc_end_i = 1'b1; rst_i = 1'b1;
    tick();
    rst_i = 1'b0; wr_valid_i = 1'b0; pri_enc_end_i = 1'b0;
    for (int a = 2; a < 5; a++) begin
      rd_sel_i = 1'b1; rd_sparsemap_addr_i = 4'(a); pri_enc_match_addr_i = 3'd5;
      #1;
      checks++;
      if (rd_sparsemap_o !== 8'h00 || rd_data_o !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid addr=%0d: got %h/%h want 00/00", a, rd_sparsemap_o, rd_data_o);
      end
      tick();
    end
  endtask

  initial begin
    rst_i = 1'b1; wr_valid_i = 1'b0; wr_sel_i = 1'b0; wr_count_i = '0;
    wr_sparsemap_i = '0; wr_nonzero_data_i = '0; rd_sel_i = 1'b0;
    pri_enc_match_addr_i = '0; pri_enc_end_i = 1'b0; chunk_end_i = 1'b0;
    rd_sparsemap_addr_i = '0; m_base = 0;
    @(negedge clk_i);
    test_reset();
    test_read_basic();
    test_base_accum();
    test_chunk_end();
    test_double_buffer();
    test_boundary();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
